// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 scan driver using binary-coded modulation with a ping-pong line buffer.
// The next row is loaded and shifted while the current row is on display.
`timescale 1ns/1ps
module hub75_bcm_scan_driver #(
    parameter int COLS       = 64,
    parameter int ROW_W      = 3,
    parameter int BPP        = 8,
    parameter int SCLK_DIV   = 4,
    parameter int RD_LAT     = 2,
    parameter int LAT_CYCLES = 2,
    parameter int BASE_TICKS = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [7:0]                         brightness,
    output logic                               mem_rd,
    output logic [3+ROW_W+$clog2(COLS)-1:0]    mem_addr,
    input  logic [5:0]                         mem_data,
    output logic                               R1,
    output logic                               G1,
    output logic                               B1,
    output logic                               R2,
    output logic                               G2,
    output logic                               B2,
    output logic                               SCLK,
    output logic                               LAT,
    output logic                               OE_N,
    output logic [ROW_W-1:0]                   ADDR,
    output logic                               frame_done
);

    localparam int CW  = $clog2(COLS);
    localparam int LDW = $clog2(COLS + RD_LAT) + 1;
    localparam int SW  = $clog2(2 * SCLK_DIV) + 1;
    localparam int LCW = $clog2(LAT_CYCLES) + 1;
    localparam int PLW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int TW  = $clog2(BASE_TICKS) + BPP + 1;
    localparam int PW  = (TW + 9 > 16) ? TW + 9 : 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_BLANK = 3'd4;
    localparam logic [2:0] S_LATCH = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [PLW-1:0]   ld_plane_q, ld_plane_d;
    logic [ROW_W-1:0] ld_row_q, ld_row_d;
    logic [LDW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]    sh_col_q, sh_col_d;
    logic [SW-1:0]    sh_ph_q, sh_ph_d;
    logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
    logic             sclk_q, sclk_d;
    logic [5:0]       data_q, data_d;
    logic [ROW_W-1:0] addr_q, addr_d;
    logic             bank_q, bank_d;
    logic [TW-1:0]    tot_left_q, tot_left_d;
    logic [TW-1:0]    on_left_q, on_left_d;
    logic             disp_last_q, disp_last_d;
    logic             frame_done_q, frame_done_d;
    logic             abort_q, abort_d;

    logic             vld_q [RD_LAT];
    logic [CW-1:0]    colp_q [RD_LAT];
    logic [5:0]       buf_q [2][COLS];

    logic [CW-1:0]    nxt_col;
    logic             last_row;
    logic             last_plane;
    logic [TW-1:0]    t_val;
    logic [TW-1:0]    on_val;

    assign nxt_col    = sh_col_q + 1'b1;
    assign last_row   = &ld_row_q;
    assign last_plane = (ld_plane_q == PLW'(BPP - 1));
    assign t_val      = TW'(BASE_TICKS) << ld_plane_q;
    assign on_val     = TW'((PW'(t_val) * (PW'(brightness) + PW'(1))) >> 8);

    assign mem_rd   = (state_q == S_LOAD) && (ld_cnt_q < LDW'(COLS));
    assign mem_addr = mem_rd ? {3'(ld_plane_q), ld_row_q, ld_cnt_q[CW-1:0]} : '0;

    assign {R1, G1, B1, R2, G2, B2} = data_q;
    assign SCLK       = sclk_q;
    assign LAT        = (state_q == S_LATCH);
    assign OE_N       = (on_left_q == '0);
    assign ADDR       = addr_q;
    assign frame_done = frame_done_q;

    // Read-return pipeline: each word lands in the buffer RD_LAT cycles after its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                colp_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= mem_rd;
            colp_q[0] <= ld_cnt_q[CW-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                colp_q[i] <= colp_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_q[RD_LAT-1]) begin
            buf_q[bank_q][colp_q[RD_LAT-1]] <= mem_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_plane_d   = ld_plane_q;
        ld_row_d     = ld_row_q;
        ld_cnt_d     = ld_cnt_q;
        sh_col_d     = sh_col_q;
        sh_ph_d      = sh_ph_q;
        lat_cnt_d    = lat_cnt_q;
        sclk_d       = sclk_q;
        data_d       = data_q;
        addr_d       = addr_q;
        bank_d       = bank_q;
        tot_left_d   = tot_left_q;
        on_left_d    = on_left_q;
        disp_last_d  = disp_last_q;
        frame_done_d = 1'b0;
        abort_d      = abort_q;

        // The display timer runs independently of the row FSM.
        if (tot_left_q != '0) begin
            tot_left_d = tot_left_q - 1'b1;
            if (on_left_q != '0) begin
                on_left_d = on_left_q - 1'b1;
            end
            if (tot_left_q == TW'(1)) begin
                frame_done_d = disp_last_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                if (enable) begin
                    state_d  = S_LOAD;
                    ld_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (!enable) begin
                    state_d = S_WAIT;
                    abort_d = 1'b1;
                end else if (ld_cnt_q == LDW'(COLS + RD_LAT - 1)) begin
                    state_d  = S_SHIFT;
                    sh_col_d = '0;
                    sh_ph_d  = '0;
                    sclk_d   = 1'b0;
                    data_d   = buf_q[bank_q][0];
                end else begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!enable) begin
                    state_d = S_WAIT;
                    abort_d = 1'b1;
                    sclk_d  = 1'b0;
                end else begin
                    sh_ph_d = sh_ph_q + 1'b1;
                    if (sh_ph_q == SW'(SCLK_DIV - 1)) begin
                        sclk_d = 1'b1;
                    end
                    if (sh_ph_q == SW'(2 * SCLK_DIV - 1)) begin
                        sclk_d  = 1'b0;
                        sh_ph_d = '0;
                        if (sh_col_q == CW'(COLS - 1)) begin
                            state_d = S_WAIT;
                        end else begin
                            sh_col_d = nxt_col;
                            data_d   = buf_q[bank_q][nxt_col];
                        end
                    end
                end
            end
            S_WAIT: begin
                sclk_d = 1'b0;
                if (tot_left_q == '0) begin
                    if (abort_q || !enable) begin
                        state_d    = S_IDLE;
                        ld_plane_d = '0;
                        ld_row_d   = '0;
                        abort_d    = 1'b0;
                    end else begin
                        state_d = S_BLANK;
                        addr_d  = ld_row_q;
                    end
                end
            end
            S_BLANK: begin
                state_d   = S_LATCH;
                lat_cnt_d = '0;
            end
            S_LATCH: begin
                if (lat_cnt_q == LCW'(LAT_CYCLES - 1)) begin
                    tot_left_d  = t_val;
                    on_left_d   = on_val;
                    disp_last_d = last_plane && last_row;
                    if (last_row) begin
                        ld_row_d   = '0;
                        ld_plane_d = last_plane ? '0 : ld_plane_q + 1'b1;
                    end else begin
                        ld_row_d = ld_row_q + 1'b1;
                    end
                    bank_d   = ~bank_q;
                    state_d  = S_LOAD;
                    ld_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ld_plane_q   <= '0;
            ld_row_q     <= '0;
            ld_cnt_q     <= '0;
            sh_col_q     <= '0;
            sh_ph_q      <= '0;
            lat_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            bank_q       <= 1'b0;
            tot_left_q   <= '0;
            on_left_q    <= '0;
            disp_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_plane_q   <= ld_plane_d;
            ld_row_q     <= ld_row_d;
            ld_cnt_q     <= ld_cnt_d;
            sh_col_q     <= sh_col_d;
            sh_ph_q      <= sh_ph_d;
            lat_cnt_q    <= lat_cnt_d;
            sclk_q       <= sclk_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            bank_q       <= bank_d;
            tot_left_q   <= tot_left_d;
            on_left_q    <= on_left_d;
            disp_last_q  <= disp_last_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
// Bench for hub75_bcm_scan_driver: a small panel with a behavioural model of the
// read order, shifted data, latch timing and BCM OE schedule.
`timescale 1ns/1ps
module tb_hub75_bcm_scan_driver;

    localparam int COLS       = 8;
    localparam int ROW_W      = 1;
    localparam int BPP        = 2;
    localparam int SCLK_DIV   = 1;
    localparam int RD_LAT     = 2;
    localparam int LAT_CYCLES = 2;
    localparam int BASE_TICKS = 16;
    localparam int WORDS      = COLS * (1 << ROW_W) * BPP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] brightness;
    logic       mem_rd;
    logic [6:0] mem_addr;
    logic [5:0] mem_data;
    logic       R1, G1, B1, R2, G2, B2;
    logic       SCLK, LAT, OE_N;
    logic [0:0] ADDR;
    logic       frame_done;

    always #5 clk = ~clk;

    hub75_bcm_scan_driver #(
        .COLS(COLS), .ROW_W(ROW_W), .BPP(BPP), .SCLK_DIV(SCLK_DIV),
        .RD_LAT(RD_LAT), .LAT_CYCLES(LAT_CYCLES), .BASE_TICKS(BASE_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .SCLK(SCLK), .LAT(LAT), .OE_N(OE_N), .ADDR(ADDR), .frame_done(frame_done)
    );

    // Pixel word: R1 follows the column LSB so the R1 stream alternates 0,1,0,1...
    function automatic logic [5:0] memWord(input logic [6:0] a);
        return {a[0], a[1], a[2], a[3], a[4], ~a[0]};
    endfunction

    logic [5:0] rdPipe [RD_LAT];
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
        rdPipe[0] <= mem_rd ? memWord(mem_addr) : 6'h0;
    end
    assign mem_data = rdPipe[RD_LAT-1];

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int   rdIdx, shIdx, latCount, latW, sCyc, curT, curOn, brightLat, run;
    bit   curLast, prevEn, prevSclk, prevLat, prevOe;
    logic [0:0] prevAddr;
    int   fdCount, overlapCycles;
    int   lowRuns[$];
    int   addrSeq[$];

    task automatic resetModel();
        rdIdx = 0; shIdx = 0; latCount = 0; latW = 0; sCyc = 100000;
        curT = 0; curOn = 0; curLast = 0; run = 0; brightLat = 0;
        prevEn = 0; prevSclk = 0; prevLat = 0; prevOe = 1; prevAddr = '0;
    endtask

    // Model of the specified behaviour, compared on every falling edge.
    always @(negedge clk) begin
        int expOe;
        int plane;
        if (!rst_n) begin
            resetModel();
        end else begin
            if (enable && !prevEn) begin
                rdIdx = 0; shIdx = 0; latCount = 0;
            end
            prevEn = enable;
            if (mem_rd) begin
                checkOutput("mem_addr", mem_addr, rdIdx % WORDS);
                rdIdx++;
            end
            if (SCLK && !prevSclk) begin
                checkOutput("rgb_at_sclk", {R1, G1, B1, R2, G2, B2}, memWord(7'(shIdx % WORDS)));
                shIdx++;
            end
            if (LAT && !prevLat) latW = 0;
            if (LAT) begin
                checkOutput("oe_during_lat", OE_N, 1);
                latW++;
                brightLat = brightness;
            end
            if (!LAT && prevLat) begin
                checkOutput("lat_width", latW, LAT_CYCLES);
                checkOutput("cols_shifted", shIdx, COLS * (latCount + 1));
                checkOutput("addr_at_latch", ADDR, latCount % 2);
                addrSeq.push_back(ADDR);
                plane   = (latCount / 2) % BPP;
                curT    = BASE_TICKS << plane;
                curOn   = (curT * (brightLat + 1)) / 256;
                curLast = ((latCount % 4) == 3);
                latCount++;
                sCyc = 1;
            end
            expOe = (sCyc >= 1 && sCyc <= curOn) ? 0 : 1;
            checkOutput("oe_n", OE_N, expOe);
            checkOutput("frame_done", frame_done, (sCyc == curT + 1 && curLast) ? 1 : 0);
            if (frame_done) fdCount++;
            if (ADDR != prevAddr) checkOutput("oe_at_addr_change", OE_N & prevOe, 1);
            if (!OE_N) run++;
            else if (run > 0) begin
                lowRuns.push_back(run);
                run = 0;
            end
            if (!OE_N && (mem_rd || SCLK)) overlapCycles++;
            if (sCyc < 100000) sCyc++;
            prevSclk = SCLK; prevLat = LAT; prevOe = OE_N; prevAddr = ADDR;
        end
    end

    task automatic applyStimulus(input bit en, input int bright);
        @(posedge clk);
        #1;
        enable     = en;
        brightness = 8'(bright);
    endtask

    task automatic waitFrame(input string name);
        bit found = 0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            if (frame_done) found = 1;
        end
        checkOutput(name, found, 1);
        @(negedge clk);
    endtask

    // which: 0 = OE_N low, 1 = SCLK high, 2 = mem_rd high
    task automatic waitSignal(input int which, input string name);
        bit found = 0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            case (which)
                0: found = !OE_N;
                1: found = SCLK;
                default: found = mem_rd;
            endcase
        end
        checkOutput(name, found, 1);
    endtask

    task automatic checkFrame(input string tag, input int r0, input int r1, input int r2, input int r3);
        int expRuns[4];
        expRuns = '{r0, r1, r2, r3};
        checkOutput({tag, "_run_count"}, lowRuns.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_low_run%0d", tag, i), (i < lowRuns.size()) ? lowRuns[i] : -1, expRuns[i]);
            checkOutput($sformatf("%s_addr%0d", tag, i), (i < addrSeq.size()) ? addrSeq[i] : -1, i % 2);
        end
        checkOutput({tag, "_frame_done_count"}, fdCount, 1);
        lowRuns.delete();
        addrSeq.delete();
        fdCount = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_oe_n"}, OE_N, 1);
        checkOutput({tag, "_sclk"}, SCLK, 0);
        checkOutput({tag, "_lat"}, LAT, 0);
        checkOutput({tag, "_addr"}, ADDR, 0);
        checkOutput({tag, "_mem_rd"}, mem_rd, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_rgb"}, {R1, G1, B1, R2, G2, B2}, 0);
    endtask

    initial begin
        fdCount = 0;
        overlapCycles = 0;
        resetModel();
        rst_n = 1'b0;
        enable = 1'b0;
        brightness = 8'd255;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full brightness: plane 0 rows on 16 cycles, plane 1 rows on 32.
        applyStimulus(1'b1, 255);
        waitFrame("frame_a_timeout");
        checkFrame("frame_a", 16, 16, 32, 32);
        checkOutput("shift_overlaps_display", (overlapCycles > 0) ? 1 : 0, 1);

        // Half brightness: On = T*128/256.
        applyStimulus(1'b1, 127);
        waitFrame("frame_b_timeout");
        checkFrame("frame_b", 8, 8, 16, 16);

        // Drop enable while a row is displaying; that row finishes, then idle.
        waitSignal(0, "oe_low_timeout");
        applyStimulus(1'b0, 127);
        repeat (100) @(negedge clk);
        checkOutput("disabled_oe_n", OE_N, 1);
        checkOutput("disabled_lat", LAT, 0);
        checkOutput("disabled_sclk", SCLK, 0);
        checkOutput("disabled_mem_rd", mem_rd, 0);
        lowRuns.delete();
        addrSeq.delete();
        fdCount = 0;
        applyStimulus(1'b1, 255);
        waitSignal(2, "reenable_read_timeout");
        checkOutput("reenable_first_addr", mem_addr, 0);
        waitFrame("frame_c_timeout");
        checkFrame("frame_c", 16, 16, 32, 32);

        // Asynchronous reset in the middle of a shift.
        waitSignal(1, "sclk_timeout");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("async_reset");
        lowRuns.delete();
        addrSeq.delete();
        fdCount = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        waitSignal(2, "post_reset_read_timeout");
        checkOutput("post_reset_first_addr", mem_addr, 0);
        waitFrame("frame_d_timeout");
        checkFrame("frame_d", 16, 16, 32, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
